// File: rtl/spi_slave_mlf.sv
// SPI peripheral endpoint, oversampled in the i_clk domain.
// SCLK, CS_n and MOSI are synchronized and edge-detected. No logic runs on SCLK.
// Local side: byte-wide TX holding register and RX byte output.
//
// Handshakes:
//   TX: a byte transfers when i_TX_DV & o_TX_Ready on a rising i_clk edge.
//       o_TX_Ready drops the following cycle and stays low until the held byte is
//       moved into the shift register. i_TX_DV is ignored while o_TX_Ready is low.
//   RX: o_RX_DV is a single-cycle pulse with no backpressure. o_RX_Byte is valid
//       with the pulse and is held until the next pulse.
// The FSM state is available as state_q for checkers bound to this module.
module spi_slave_mlf #(
  parameter int unsigned SPI_MODE         = 0,
  parameter int unsigned MAX_BYTES_PER_CS = 2,
  parameter logic [7:0]  DEFAULT_TX       = 8'h00
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_TX_DV,
  input  logic [7:0]                            i_TX_Byte,
  output logic                                  o_TX_Ready,
  output logic                                  o_TX_underrun,
  output logic                                  o_RX_DV,
  output logic [7:0]                            o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_count,
  output logic                                  o_CS_active,
  input  logic                                  i_SPI_clk,
  input  logic                                  i_SPI_CS_n,
  input  logic                                  i_SPI_MOSI,
  output logic                                  o_SPI_MISO,
  output logic                                  o_SPI_MISO_oe
);

  localparam int unsigned CW   = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [1:0]  MODE = SPI_MODE[1:0];
  localparam logic        CPOL = MODE[1];
  localparam logic        CPHA = MODE[0];

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  // [0] first stage, [1] synchronized value, [2] one cycle older (edge detect)
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  state_t         state_q, state_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic [2:0]     tx_idx_q, tx_idx_d;
  logic           load_pend_q, load_pend_d;
  logic           miso_q, miso_d;
  logic           cs_active_q, cs_active_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           rx_dv_q, rx_dv_d;
  logic [CW-1:0]  rx_count_q, rx_count_d;
  logic           underrun_q, underrun_d;

  logic       sclk_s, sclk_old, cs_n_s, mosi_s;
  logic       lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
  logic       load;
  logic [7:0] load_byte;

  assign sclk_s      = sclk_sync_q[1];
  assign sclk_old    = sclk_sync_q[2];
  assign cs_n_s      = cs_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign lead_edge   = (sclk_old == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_old != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_sync_q[2] & ~cs_sync_q[1];
  assign load_byte   = hold_full_q ? hold_q : DEFAULT_TX;

  // Synchronizers; CS resets to "asserted" so a frame in progress at reset release is not mistaken for idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q <= {3{CPOL}};
      cs_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], i_SPI_clk};
      cs_sync_q   <= {cs_sync_q[1:0], i_SPI_CS_n};
      mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
    end
  end

  // Next-state logic: FSM, TX holding/shift path, RX shift path
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_shift_d  = tx_shift_q;
    tx_idx_d    = tx_idx_q;
    load_pend_d = load_pend_q;
    miso_d      = miso_q;
    cs_active_d = cs_active_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    rx_count_d  = rx_count_q;
    underrun_d  = 1'b0;
    load        = 1'b0;

    if (i_TX_DV && !hold_full_q) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end

    case (state_q)
      WAIT_IDLE: begin
        if (cs_n_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          cs_active_d = 1'b1;
          rx_count_d  = '0;
          bit_cnt_d   = 3'd7;
          load_pend_d = 1'b0;
          load        = 1'b1;
          // With CPHA=1 bit 7 waits for the first shift edge
          if (CPHA) begin
            tx_idx_d = 3'd7;
          end else begin
            miso_d   = load_byte[7];
            tx_idx_d = 3'd6;
          end
        end
      end
      ACTIVE: begin
        if (cs_n_s) begin
          state_d     = IDLE;
          cs_active_d = 1'b0;
          miso_d      = 1'b0;
          load_pend_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            if (bit_cnt_q == 3'd0) begin
              rx_byte_d   = {rx_shift_q[6:0], mosi_s};
              rx_dv_d     = 1'b1;
              bit_cnt_d   = 3'd7;
              load_pend_d = 1'b1;
              if (rx_count_q != CW'(MAX_BYTES_PER_CS)) rx_count_d = rx_count_q + CW'(1);
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
          if (shift_edge) begin
            if (load_pend_q) begin
              load        = 1'b1;
              load_pend_d = 1'b0;
              miso_d      = load_byte[7];
              tx_idx_d    = 3'd6;
            end else begin
              miso_d   = tx_shift_q[tx_idx_q];
              tx_idx_d = tx_idx_q - 3'd1;
            end
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    // A byte accepted this cycle only ever lands in the holding register
    if (load) begin
      tx_shift_d = load_byte;
      if (hold_full_q) hold_full_d = 1'b0;
      else             underrun_d  = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= WAIT_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_shift_q  <= 8'h00;
      tx_idx_q    <= 3'd7;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      cs_active_q <= 1'b0;
      bit_cnt_q   <= 3'd7;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_dv_q     <= 1'b0;
      rx_count_q  <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_shift_q  <= tx_shift_d;
      tx_idx_q    <= tx_idx_d;
      load_pend_q <= load_pend_d;
      miso_q      <= miso_d;
      cs_active_q <= cs_active_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      rx_count_q  <= rx_count_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_TX_Ready    = ~hold_full_q;
  assign o_TX_underrun = underrun_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_count    = rx_count_q;
  assign o_CS_active   = cs_active_q;
  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_oe = cs_active_q;

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Bench for spi_slave_mlf: one instance per SPI mode, a bit-banged SPI master,
// an RX scoreboard for the mode-0 instance and directed scenario tasks.
module tb_spi_slave_mlf;

  localparam int HALF = 8;  // i_clk cycles per SCLK half period

  logic       clk;
  logic       rst_n;
  logic [3:0] tx_dv;
  logic [7:0] tx_byte [4];
  logic [3:0] tx_ready;
  logic [3:0] underrun;
  logic [3:0] rx_dv;
  logic [7:0] rx_byte [4];
  logic [1:0] rx_count [4];
  logic [3:0] cs_active;
  logic [3:0] sclk;
  logic [3:0] cs_n;
  logic [3:0] mosi;
  logic [3:0] miso;
  logic [3:0] miso_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];      // expected RX bytes for the mode-0 instance
  int         rx_dv_cnt [4];
  logic [7:0] rx_last [4];
  int         underrun_cnt [4];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_mlf #(
      .SPI_MODE(g), .MAX_BYTES_PER_CS(2), .DEFAULT_TX(8'h00)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_TX_DV(tx_dv[g]), .i_TX_Byte(tx_byte[g]),
      .o_TX_Ready(tx_ready[g]), .o_TX_underrun(underrun[g]),
      .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]), .o_RX_count(rx_count[g]),
      .o_CS_active(cs_active[g]),
      .i_SPI_clk(sclk[g]), .i_SPI_CS_n(cs_n[g]), .i_SPI_MOSI(mosi[g]),
      .o_SPI_MISO(miso[g]), .o_SPI_MISO_oe(miso_oe[g])
    );
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n) begin
      if (rx_dv[0]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected got=%h expected=no_rx_dv", rx_byte[0]);
        end else begin
          e = exp_q.pop_front();
          if (rx_byte[0] !== e) begin
            bad++;
            $display("FAIL rx_byte got=%h expected=%h", rx_byte[0], e);
          end
        end
      end
      for (int m = 0; m < 4; m++) begin
        if (rx_dv[m]) begin
          rx_dv_cnt[m]++;
          rx_last[m] = rx_byte[m];
        end
        if (underrun[m]) underrun_cnt[m]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic tx_push(input int m, input logic [7:0] b);
    int n = 0;
    while (tx_ready[m] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready[m] !== 1'b1) begin
      bad++;
      $display("FAIL tx_ready_wait m=%0d got=%b expected=1", m, tx_ready[m]);
    end
    tx_dv[m]   = 1'b1;
    tx_byte[m] = b;
    @(negedge clk);
    tx_dv[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    half();
  endtask

  task automatic cs_high(input int m);
    cs_n[m] = 1'b1;
    repeat (4) @(negedge clk);
    half();
  endtask

  // Master side of one byte (or its first nbits bits), MSB first
  task automatic spi_xfer(input int m, input logic [7:0] txb, input int nbits,
                          output logic [7:0] rxb);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    rxb  = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = txb[i];
        half();
        sclk[m] = ~cpol;
        rxb[i]  = miso[m];
        half();
        sclk[m] = cpol;
      end else begin
        half();
        sclk[m] = ~cpol;
        mosi[m] = txb[i];
        half();
        sclk[m] = cpol;
        rxb[i]  = miso[m];
      end
    end
    half();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    total += 8;
    if (tx_ready[0] !== 1'b1)   begin bad++; $display("FAIL rst_tx_ready got=%b expected=1", tx_ready[0]); end
    if (underrun[0] !== 1'b0)   begin bad++; $display("FAIL rst_underrun got=%b expected=0", underrun[0]); end
    if (rx_dv[0] !== 1'b0)      begin bad++; $display("FAIL rst_rx_dv got=%b expected=0", rx_dv[0]); end
    if (rx_byte[0] !== 8'h00)   begin bad++; $display("FAIL rst_rx_byte got=%h expected=00", rx_byte[0]); end
    if (rx_count[0] !== 2'd0)   begin bad++; $display("FAIL rst_rx_count got=%0d expected=0", rx_count[0]); end
    if (cs_active[0] !== 1'b0)  begin bad++; $display("FAIL rst_cs_active got=%b expected=0", cs_active[0]); end
    if (miso[0] !== 1'b0)       begin bad++; $display("FAIL rst_miso got=%b expected=0", miso[0]); end
    if (miso_oe[0] !== 1'b0)    begin bad++; $display("FAIL rst_miso_oe got=%b expected=0", miso_oe[0]); end
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    int u0;
    tx_push(0, 8'hA5);
    total++;
    if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL t1_ready_fall got=%b expected=0", tx_ready[0]); end
    u0 = underrun_cnt[0];
    exp_q.push_back(8'h66);
    cs_n[0] = 1'b0;
    repeat (4) @(negedge clk);
    total += 4;
    if (miso[0] !== 1'b1)      begin bad++; $display("FAIL t1_miso_bit7 got=%b expected=1", miso[0]); end
    if (miso_oe[0] !== 1'b1)   begin bad++; $display("FAIL t1_miso_oe got=%b expected=1", miso_oe[0]); end
    if (cs_active[0] !== 1'b1) begin bad++; $display("FAIL t1_cs_active got=%b expected=1", cs_active[0]); end
    if (tx_ready[0] !== 1'b1)  begin bad++; $display("FAIL t1_ready_after_load got=%b expected=1", tx_ready[0]); end
    half();
    total++;
    if (underrun_cnt[0] != u0) begin bad++; $display("FAIL t1_no_underrun got=%0d expected=%0d", underrun_cnt[0], u0); end
    spi_xfer(0, 8'h66, 8, got);
    total += 2;
    if (got !== 8'hA5)         begin bad++; $display("FAIL t1_master_rx got=%h expected=a5", got); end
    if (rx_count[0] !== 2'd1)  begin bad++; $display("FAIL t1_rx_count got=%0d expected=1", rx_count[0]); end
    cs_high(0);
    total += 5;
    if (cs_active[0] !== 1'b0) begin bad++; $display("FAIL t1_cs_inactive got=%b expected=0", cs_active[0]); end
    if (miso_oe[0] !== 1'b0)   begin bad++; $display("FAIL t1_oe_off got=%b expected=0", miso_oe[0]); end
    if (miso[0] !== 1'b0)      begin bad++; $display("FAIL t1_miso_off got=%b expected=0", miso[0]); end
    if (rx_byte[0] !== 8'h66)  begin bad++; $display("FAIL t1_rx_byte_held got=%h expected=66", rx_byte[0]); end
    if (exp_q.size() != 0)     begin bad++; $display("FAIL t1_rx_missing got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_two_byte();
    logic [7:0] got;
    exp_q.push_back(8'h66);
    exp_q.push_back(8'hC2);
    tx_push(0, 8'h3C);
    cs_low(0);
    tx_push(0, 8'h81);
    spi_xfer(0, 8'h66, 8, got);
    total += 2;
    if (got !== 8'h3C)         begin bad++; $display("FAIL t2_master_rx0 got=%h expected=3c", got); end
    if (rx_count[0] !== 2'd1)  begin bad++; $display("FAIL t2_rx_count1 got=%0d expected=1", rx_count[0]); end
    spi_xfer(0, 8'hC2, 8, got);
    total += 2;
    if (got !== 8'h81)         begin bad++; $display("FAIL t2_master_rx1 got=%h expected=81", got); end
    if (rx_count[0] !== 2'd2)  begin bad++; $display("FAIL t2_rx_count2 got=%0d expected=2", rx_count[0]); end
    cs_high(0);
    total++;
    if (exp_q.size() != 0)     begin bad++; $display("FAIL t2_rx_missing got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    int u0;
    exp_q.push_back(8'h5A);
    u0 = underrun_cnt[0];
    cs_low(0);
    total++;
    if (underrun_cnt[0] - u0 != 1) begin bad++; $display("FAIL t3_underrun_pulses got=%0d expected=1", underrun_cnt[0] - u0); end
    spi_xfer(0, 8'h5A, 8, got);
    total += 2;
    if (got !== 8'h00)         begin bad++; $display("FAIL t3_master_rx got=%h expected=00", got); end
    if (rx_count[0] !== 2'd1)  begin bad++; $display("FAIL t3_rx_count got=%0d expected=1", rx_count[0]); end
    cs_high(0);
    total++;
    if (exp_q.size() != 0)     begin bad++; $display("FAIL t3_rx_missing got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_cs_abort();
    logic [7:0] got;
    cs_low(0);
    spi_xfer(0, 8'hF0, 4, got);
    cs_high(0);
    total++;
    if (rx_count[0] !== 2'd0)  begin bad++; $display("FAIL t4_count_partial got=%0d expected=0", rx_count[0]); end
    exp_q.push_back(8'h0F);
    cs_low(0);
    spi_xfer(0, 8'h0F, 8, got);
    cs_high(0);
    total += 3;
    if (rx_count[0] !== 2'd1)  begin bad++; $display("FAIL t4_rx_count got=%0d expected=1", rx_count[0]); end
    if (rx_byte[0] !== 8'h0F)  begin bad++; $display("FAIL t4_rx_byte got=%h expected=0f", rx_byte[0]); end
    if (exp_q.size() != 0)     begin bad++; $display("FAIL t4_rx_missing got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    tx_push(0, 8'h77);
    cs_low(0);
    tx_push(0, 8'h99);
    spi_xfer(0, 8'hD4, 5, got);
    total++;
    if (tx_ready[0] !== 1'b0)  begin bad++; $display("FAIL t5_pending_before got=%b expected=0", tx_ready[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    total += 6;
    if (tx_ready[0] !== 1'b1)  begin bad++; $display("FAIL t5_rst_tx_ready got=%b expected=1", tx_ready[0]); end
    if (cs_active[0] !== 1'b0) begin bad++; $display("FAIL t5_rst_cs_active got=%b expected=0", cs_active[0]); end
    if (miso_oe[0] !== 1'b0)   begin bad++; $display("FAIL t5_rst_oe got=%b expected=0", miso_oe[0]); end
    if (miso[0] !== 1'b0)      begin bad++; $display("FAIL t5_rst_miso got=%b expected=0", miso[0]); end
    if (rx_count[0] !== 2'd0)  begin bad++; $display("FAIL t5_rst_rx_count got=%0d expected=0", rx_count[0]); end
    if (rx_byte[0] !== 8'h00)  begin bad++; $display("FAIL t5_rst_rx_byte got=%h expected=00", rx_byte[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spi_xfer(0, 8'hFF, 8, got);
    total += 2;
    if (cs_active[0] !== 1'b0) begin bad++; $display("FAIL t5_ignored_frame got=%b expected=0", cs_active[0]); end
    if (miso_oe[0] !== 1'b0)   begin bad++; $display("FAIL t5_ignored_oe got=%b expected=0", miso_oe[0]); end
    cs_high(0);
    tx_push(0, 8'hE7);
    exp_q.push_back(8'h3B);
    cs_low(0);
    spi_xfer(0, 8'h3B, 8, got);
    cs_high(0);
    total += 3;
    if (got !== 8'hE7)         begin bad++; $display("FAIL t5_master_rx got=%h expected=e7", got); end
    if (rx_count[0] !== 2'd1)  begin bad++; $display("FAIL t5_rx_count got=%0d expected=1", rx_count[0]); end
    if (exp_q.size() != 0)     begin bad++; $display("FAIL t5_rx_missing got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_modes();
    logic [7:0] got;
    for (int m = 1; m < 4; m++) begin
      rx_dv_cnt[m] = 0;
      tx_push(m, 8'h96);
      cs_low(m);
      spi_xfer(m, 8'h69, 8, got);
      total += 3;
      if (got !== 8'h96)        begin bad++; $display("FAIL t6_master_rx mode=%0d got=%h expected=96", m, got); end
      if (rx_dv_cnt[m] != 1)    begin bad++; $display("FAIL t6_rx_dv_count mode=%0d got=%0d expected=1", m, rx_dv_cnt[m]); end
      if (rx_last[m] !== 8'h69) begin bad++; $display("FAIL t6_rx_byte mode=%0d got=%h expected=69", m, rx_last[m]); end
      cs_high(m);
      total++;
      if (rx_count[m] !== 2'd1) begin bad++; $display("FAIL t6_rx_count mode=%0d got=%0d expected=1", m, rx_count[m]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sclk[m]         = (m >= 2);
      cs_n[m]         = 1'b1;
      mosi[m]         = 1'b0;
      tx_dv[m]        = 1'b0;
      tx_byte[m]      = 8'h00;
      rx_dv_cnt[m]    = 0;
      rx_last[m]      = 8'h00;
      underrun_cnt[m] = 0;
    end
    test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    test_single_byte();
    test_two_byte();
    test_underrun();
    test_cs_abort();
    test_reset_mid_frame();
    test_modes();
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
